// File: rtl/fc_weight_streamer_pkg.sv
`default_nettype none
// ============================================================================
// fc_weight_streamer_pkg : shared weight-width default and streamer FSM states
// Rev 1.0
// ============================================================================
package fc_weight_streamer_pkg;

    localparam int c_BITSIZE_DEFAULT = 14;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fc_weight_bank.sv
`default_nettype none
// ============================================================================
// fc_weight_bank : DEPTH x BITSIZE weight RAM, one write port, one read port
// Rev 1.0
// ============================================================================
module fc_weight_bank
    import fc_weight_streamer_pkg::*;
#(
    parameter int BITSIZE = c_BITSIZE_DEFAULT,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic signed [BITSIZE-1:0] wdata,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         raddr,
    output logic signed [BITSIZE-1:0] rdata
);

    logic signed [BITSIZE-1:0] r_mem [DEPTH];

    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_weight_streamer.sv
`default_nettype none
// ============================================================================
// fc_weight_streamer : streams LANES parallel weight words per beat from banked RAM
// Rev 1.0
// ============================================================================
module fc_weight_streamer
    import fc_weight_streamer_pkg::*;
#(
    parameter int BITSIZE = c_BITSIZE_DEFAULT,
    parameter int DEPTH   = 1024,
    parameter int LANES   = 4,
    parameter int ADDR_W  = $clog2(DEPTH),
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [LANE_W-1:0]          wr_lane,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic signed [BITSIZE-1:0]  data_in,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W:0]            length,
    input  logic                       loop,
    input  logic                       abort,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [LANES*BITSIZE-1:0]   data_out,
    output logic                       busy,
    output logic                       done
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_ptr;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W:0]         r_length;
    logic [ADDR_W:0]         r_issued;
    logic                    r_loop;
    logic                    r_valid;
    logic                    r_done;
    logic                    w_issue;
    logic                    w_end;
    logic                    w_pass_last;
    logic [ADDR_W-1:0]       w_ptr_inc;
    logic [LANES*BITSIZE-1:0] w_rd;

    assign w_pass_last = ((r_issued + (ADDR_W+1)'(1)) == r_length);
    assign w_ptr_inc   = (r_ptr == ADDR_W'(DEPTH-1)) ? '0 : r_ptr + ADDR_W'(1);

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_bank
            logic signed [BITSIZE-1:0] w_q;

            fc_weight_bank #(
                .BITSIZE (BITSIZE),
                .DEPTH   (DEPTH),
                .ADDR_W  (ADDR_W)
            ) u_bank (
                .clk   (clk),
                .we    (wr && (wr_lane == LANE_W'(k))),
                .waddr (wr_addr),
                .wdata (data_in),
                .re    (w_issue),
                .raddr (r_ptr),
                .rdata (w_q)
            );

            assign w_rd[k*BITSIZE +: BITSIZE] = w_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only one beat can be outstanding, so with every beat issued the beat
    // being accepted is the last of a non-looping pass.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = !abort && (!r_valid || out_ready) && (r_issued < r_length);
                w_end   = !abort && r_valid && out_ready && !r_loop && (r_issued == r_length);
                if (abort || w_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_base   <= '0;
            r_length <= '0;
            r_issued <= '0;
            r_loop   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    if (length == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_base   <= base_addr;
                        r_length <= length;
                        r_loop   <= loop;
                        r_ptr    <= base_addr;
                        r_issued <= '0;
                    end
                end
            end else if (abort) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                if (w_issue) begin
                    r_valid <= 1'b1;
                    // Looping passes restart at base right behind the last issue.
                    if (r_loop && w_pass_last) begin
                        r_ptr    <= r_base;
                        r_issued <= '0;
                    end else begin
                        r_ptr    <= w_ptr_inc;
                        r_issued <= r_issued + (ADDR_W+1)'(1);
                    end
                end else if (out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign data_out  = r_valid ? w_rd : '0;
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done | w_end;

endmodule
`default_nettype wire
